// File: rtl/player_controller.sv
// Per-player motion and chop/extinguisher controller.
// All motion and action updates happen once per frame, on the vsync rising edge.
module player_controller #(
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 1024 - WIDTH,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 768 - HEIGHT,
    parameter int STEP        = 2,
    parameter int X_INIT      = 64,
    parameter int Y_INIT      = 64,
    parameter int CHOP_FRAMES = 60
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        vsync_in,
    input  logic        up_in,
    input  logic        down_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        action_in,
    input  logic        at_board_in,
    input  logic [3:0]  blocked_in,
    input  logic        hold_load_in,
    input  logic [3:0]  hold_state_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  player_direction,
    output logic [3:0]  player_state,
    output logic        chop_done_out
);

    typedef enum logic {FREE, CHOP} fsm_e;

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    localparam logic [3:0] ST_NOTHING  = 4'd0;
    localparam logic [3:0] ST_CHOPPING = 4'd1;
    localparam logic [3:0] ST_EXT_OFF  = 4'd9;
    localparam logic [3:0] ST_EXT_ON   = 4'd10;
    localparam logic [3:0] ST_MAX      = 4'd10;

    localparam int CW = $clog2(CHOP_FRAMES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CHOP_FRAMES - 2);

    localparam logic [11:0] X_LO   = 12'(X_MIN + STEP);
    localparam logic [11:0] X_HI   = 12'(X_MAX - STEP);
    localparam logic [11:0] XSTEP  = 12'(STEP);
    localparam logic [10:0] Y_LO   = 11'(Y_MIN + STEP);
    localparam logic [10:0] Y_HI   = 11'(Y_MAX - STEP);
    localparam logic [10:0] YSTEP  = 11'(STEP);

    logic          vsync_q;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic [3:0]    hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fsm_e          fsm_q, fsm_d;
    logic          done_q, done_d;

    logic          tick;
    logic          any_btn;
    logic [1:0]    sel_dir;
    logic          sel_blk;
    logic [11:0]   xe;
    logic [10:0]   ye;

    assign tick    = vsync_in & ~vsync_q;
    assign any_btn = up_in | down_in | left_in | right_in;
    assign xe      = {1'b0, x_q};
    assign ye      = {1'b0, y_q};

    always_comb begin
        sel_dir = DIR_R;
        sel_blk = blocked_in[0];
        if (up_in) begin
            sel_dir = DIR_U;
            sel_blk = blocked_in[3];
        end else if (down_in) begin
            sel_dir = DIR_D;
            sel_blk = blocked_in[2];
        end else if (left_in) begin
            sel_dir = DIR_L;
            sel_blk = blocked_in[1];
        end
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        dir_d  = dir_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        fsm_d  = fsm_q;
        done_d = 1'b0;

        if (tick) begin
            if (fsm_q == FREE) begin
                if (any_btn) begin
                    dir_d = sel_dir;
                    if (!sel_blk) begin
                        case (sel_dir)
                            DIR_L: x_d = (xe < X_LO) ? 11'(X_MIN) : 11'(xe - XSTEP);
                            DIR_R: x_d = (xe > X_HI) ? 11'(X_MAX) : 11'(xe + XSTEP);
                            DIR_U: y_d = (ye < Y_LO) ? 10'(Y_MIN) : 10'(ye - YSTEP);
                            DIR_D: y_d = (ye > Y_HI) ? 10'(Y_MAX) : 10'(ye + YSTEP);
                            default: ;
                        endcase
                    end
                end else if (action_in && at_board_in && hold_q == ST_NOTHING) begin
                    fsm_d = CHOP;
                    cnt_d = '0;
                end
                if (hold_q == ST_EXT_OFF && action_in) begin
                    hold_d = ST_EXT_ON;
                end else if (hold_q == ST_EXT_ON && !action_in) begin
                    hold_d = ST_EXT_OFF;
                end
            end else begin
                // Any interruption abandons the chop without moving.
                if (any_btn || !action_in || !at_board_in) begin
                    fsm_d = FREE;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    fsm_d  = FREE;
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Game-logic loads override an extinguisher toggle on the same cycle.
        if (fsm_q == FREE && hold_load_in &&
            hold_state_in != ST_CHOPPING && hold_state_in <= ST_MAX) begin
            hold_d = hold_state_in;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            vsync_q <= 1'b0;
            x_q     <= 11'(X_INIT);
            y_q     <= 10'(Y_INIT);
            dir_q   <= DIR_D;
            hold_q  <= ST_NOTHING;
            cnt_q   <= '0;
            fsm_q   <= FREE;
            done_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            fsm_q   <= fsm_d;
            done_q  <= done_d;
        end
    end

    assign x_out            = x_q;
    assign y_out            = y_q;
    assign player_direction = dir_q;
    assign player_state     = (fsm_q == CHOP) ? ST_CHOPPING : hold_q;
    assign chop_done_out    = done_q;

endmodule

// File: tb/tb_player_controller.sv
// Directed-vector bench for player_controller.
// Each frame pushes its hand-computed outputs; a monitor checks them after the tick.
module tb_player_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        action = 1'b0, at_board = 1'b0;
    logic [3:0]  blocked = 4'b0;
    logic        hold_load = 1'b0;
    logic [3:0]  hold_state = 4'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [1:0]  dir_out;
    logic [3:0]  st_out;
    logic        done_out;

    localparam int L = 0, R = 1, U = 2, D = 3;

    typedef struct {
        string       nm;
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  d;
        logic [3:0]  s;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   pulses = 0;

    player_controller dut (
        .pixel_clk_in     (clk),
        .rst_n_in         (rst_n),
        .vsync_in         (vsync),
        .up_in            (up),
        .down_in          (down),
        .left_in          (left),
        .right_in         (right),
        .action_in        (action),
        .at_board_in      (at_board),
        .blocked_in       (blocked),
        .hold_load_in     (hold_load),
        .hold_state_in    (hold_state),
        .x_out            (x_out),
        .y_out            (y_out),
        .player_direction (dir_out),
        .player_state     (st_out),
        .chop_done_out    (done_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done_out === 1'b1) pulses++;

    // Monitor: outputs settle one cycle after the vsync rise.
    initial begin
        exp_t e;
        forever begin
            @(posedge vsync);
            @(negedge clk);
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty: got a frame with no expected entry, want one");
            end else begin
                e = sb.pop_front();
                if ({x_out, y_out, dir_out, st_out, done_out} !==
                    {e.x, e.y, e.d, e.s, e.dn}) begin
                    n_bad++;
                    $display("FAIL %s: got x=%0d y=%0d dir=%0d st=%0d done=%0b, want x=%0d y=%0d dir=%0d st=%0d done=%0b",
                             e.nm, x_out, y_out, dir_out, st_out, done_out,
                             e.x, e.y, e.d, e.s, e.dn);
                end
            end
        end
    end

    task automatic push(input string nm, input int x, input int y,
                        input int d, input int s, input bit dn);
        exp_t e;
        e.nm = nm;
        e.x  = 11'(x);
        e.y  = 10'(y);
        e.d  = 2'(d);
        e.s  = 4'(s);
        e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic frame(input string nm, input int x, input int y,
                         input int d, input int s, input bit dn);
        push(nm, x, y, d, s, dn);
        vsync = 1'b1;
        @(negedge clk);
        hold_load = 1'b0;
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] v);
        hold_load  = 1'b1;
        hold_state = v;
        @(negedge clk);
        hold_load  = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        frame("reset_vals", 64, 64, D, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) frame("idle", 64, 64, D, 0, 0);

        right = 1'b1;
        for (int i = 1; i <= 5; i++) frame("right_step", 64 + 2 * i, 64, R, 0, 0);
        blocked = 4'b0001;
        frame("right_blocked", 74, 64, R, 0, 0);
        right = 1'b0;
        left = 1'b1;
        blocked = 4'b0010;
        frame("left_blocked", 74, 64, L, 0, 0);
        blocked = 4'b0000;
        for (int i = 1; i <= 37; i++) frame("left_walk", 74 - 2 * i, 64, L, 0, 0);
        frame("left_no_wrap", 0, 64, L, 0, 0);
        up = 1'b1;
        frame("up_over_left", 0, 62, U, 0, 0);
        up = 1'b0;
        left = 1'b0;

        right = 1'b1;
        for (int i = 1; i <= 496; i++) frame("right_walk", 2 * i, 62, R, 0, 0);
        frame("right_clamp", 992, 62, R, 0, 0);
        right = 1'b0;
        up = 1'b1;
        for (int i = 1; i <= 31; i++) frame("up_walk", 992, 62 - 2 * i, U, 0, 0);
        frame("top_clamp", 992, 0, U, 0, 0);
        up = 1'b0;
        down = 1'b1;
        for (int i = 1; i <= 368; i++) frame("down_walk", 992, 2 * i, D, 0, 0);
        frame("bottom_clamp", 992, 736, D, 0, 0);
        down = 1'b0;
        up = 1'b1;
        frame("up_one", 992, 734, U, 0, 0);
        up = 1'b0;

        at_board = 1'b1;
        action = 1'b1;
        for (int i = 1; i <= 59; i++) frame("chopping", 992, 734, U, 1, 0);
        frame("chop_done", 992, 734, U, 0, 1);
        action = 1'b0;
        at_board = 1'b0;
        frame("after_chop", 992, 734, U, 0, 0);

        at_board = 1'b1;
        action = 1'b1;
        for (int i = 1; i <= 29; i++) frame("chop_b", 992, 734, U, 1, 0);
        action = 1'b0;
        frame("chop_action_drop", 992, 734, U, 0, 0);

        action = 1'b1;
        for (int i = 1; i <= 10; i++) frame("chop_c", 992, 734, U, 1, 0);
        down = 1'b1;
        frame("chop_down_abort", 992, 734, U, 0, 0);
        down = 1'b0;
        action = 1'b0;
        at_board = 1'b0;
        frame("after_abort", 992, 734, U, 0, 0);

        load(4'd9);
        action = 1'b1;
        frame("ext_on", 992, 734, U, 10, 0);
        action = 1'b0;
        frame("ext_off", 992, 734, U, 9, 0);
        load(4'd12);
        frame("load_12_ignored", 992, 734, U, 9, 0);
        load(4'd1);
        frame("load_1_ignored", 992, 734, U, 9, 0);
        action = 1'b1;
        frame("ext_on_again", 992, 734, U, 10, 0);
        action = 1'b0;
        hold_load = 1'b1;
        hold_state = 4'd5;
        frame("load_beats_toggle", 992, 734, U, 5, 0);
        load(4'd0);
        frame("load_nothing", 992, 734, U, 0, 0);
        at_board = 1'b1;
        action = 1'b1;
        frame("chop_d", 992, 734, U, 1, 0);
        load(4'd7);
        frame("load_in_chop", 992, 734, U, 1, 0);
        action = 1'b0;
        frame("chop_d_exit", 992, 734, U, 0, 0);
        at_board = 1'b0;

        left = 1'b1;
        frame("left_a", 990, 734, L, 0, 0);
        frame("left_b", 988, 734, L, 0, 0);
        left = 1'b0;
        right = 1'b1;
        push("long_vsync", 990, 734, R, 0, 0);
        vsync = 1'b1;
        repeat (100) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        right = 1'b0;
        frame("after_long_vsync", 990, 734, R, 0, 0);

        at_board = 1'b1;
        action = 1'b1;
        for (int i = 1; i <= 5; i++) frame("chop_e", 990, 734, R, 1, 0);
        rst_n = 1'b0;
        frame("reset_mid_chop", 64, 64, D, 0, 0);
        action = 1'b0;
        at_board = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        frame("post_reset", 64, 64, D, 0, 0);

        repeat (4) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        n_vec++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL chop_pulse_count: got %0d, want 1", pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
